// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO ownership: results are computed at launch, held as pending,
// and committed after a programmable latency unless cancelled or reset.
module md_unit #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       mdctr,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hiwrite,
    input  logic             lowrite,
    input  logic [WIDTH-1:0] wdata,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned MaxLat = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int unsigned CntW   = $clog2(MaxLat + 1);

    localparam logic [2:0] OpMult  = 3'b001;
    localparam logic [2:0] OpMultu = 3'b010;
    localparam logic [2:0] OpDiv   = 3'b011;
    localparam logic [2:0] OpDivu  = 3'b100;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  pend_hi_q, pend_hi_d;
    logic [WIDTH-1:0]  pend_lo_q, pend_lo_d;
    logic              pend_upd_q, pend_upd_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic              done_q, done_d;

    logic              op_valid, is_mul, is_signed, accept, div_zero;
    logic [2*WIDTH-1:0] ext_a, ext_b, prod;
    logic              a_neg, b_neg;
    logic [WIDTH-1:0]  a_mag, b_mag, q_mag, r_mag, quot, rem;

    always_comb begin
        op_valid  = (mdctr == OpMult) || (mdctr == OpMultu) ||
                    (mdctr == OpDiv)  || (mdctr == OpDivu);
        is_mul    = (mdctr == OpMult) || (mdctr == OpMultu);
        is_signed = (mdctr == OpMult) || (mdctr == OpDiv);
        accept    = (state_q == StIdle) && start && op_valid && !cancel;
        div_zero  = (b == '0);
    end

    // Low 2*WIDTH bits of a product of sign-extended operands equal the signed product.
    always_comb begin
        ext_a = is_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        ext_b = is_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        prod  = ext_a * ext_b;
    end

    // Sign-magnitude division; most-negative / -1 wraps to most-negative with zero remainder.
    always_comb begin
        a_neg = is_signed && a[WIDTH-1];
        b_neg = is_signed && b[WIDTH-1];
        a_mag = a_neg ? (~a + 1'b1) : a;
        b_mag = b_neg ? (~b + 1'b1) : b;
        if (b_mag == '0) begin
            q_mag = '0;
            r_mag = '0;
        end else begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
        quot = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
        rem  = a_neg ? (~r_mag + 1'b1) : r_mag;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pend_hi_d  = pend_hi_q;
        pend_lo_d  = pend_lo_q;
        pend_upd_d = pend_upd_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d    = StRun;
                    cnt_d      = is_mul ? CntW'(MULT_LAT) : CntW'(DIV_LAT);
                    pend_hi_d  = is_mul ? prod[2*WIDTH-1:WIDTH] : rem;
                    pend_lo_d  = is_mul ? prod[WIDTH-1:0] : quot;
                    pend_upd_d = is_mul || !div_zero;
                end else if (!cancel) begin
                    if (hiwrite) hi_d = wdata;
                    if (lowrite) lo_d = wdata;
                end
            end
            StRun: begin
                if (cancel) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == CntW'(1)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    if (pend_upd_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            pend_hi_q  <= '0;
            pend_lo_q  <= '0;
            pend_upd_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_hi_q  <= pend_hi_d;
            pend_lo_q  <= pend_lo_d;
            pend_upd_q <= pend_upd_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
        end
    end

    assign busy = (state_q == StRun);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: driver pushes expected busy lengths and commit values,
// a negedge monitor pops them when the DUT shows busy runs and done pulses.
module tb_md_unit;

    localparam int unsigned ML = 5;
    localparam int unsigned DL = 10;

    logic        clk = 1'b0;
    logic        reset, start, hiwrite, lowrite, cancel;
    logic [2:0]  mdctr;
    logic [31:0] a, b, wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    md_unit #(.WIDTH(32), .MULT_LAT(ML), .DIV_LAT(DL)) dut (
        .clk(clk), .reset(reset), .start(start), .mdctr(mdctr), .a(a), .b(b),
        .hiwrite(hiwrite), .lowrite(lowrite), .wdata(wdata), .cancel(cancel),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [31:0] hi_m, lo_m;
    int          busy_exp[$];
    logic [63:0] done_exp[$];
    int          run_len = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            busy_exp.delete();
            done_exp.delete();
            run_len = 0;
        end else begin
            if (done) begin
                if (done_exp.size() == 0) check("unexpected_done", 64'(done), 64'd0);
                else check("done_hilo", {hi, lo}, done_exp.pop_front());
            end
            if (busy) run_len++;
            else if (run_len > 0) begin
                if (busy_exp.size() == 0) check("unexpected_busy", 64'(run_len), 64'd0);
                else check("busy_len", 64'(run_len), 64'(busy_exp.pop_front()));
                run_len = 0;
            end
        end
    end

    function automatic int lat_of(input logic [2:0] c);
        if (c == 3'd1 || c == 3'd2) return ML;
        if (c == 3'd3 || c == 3'd4) return DL;
        return 0;
    endfunction

    function automatic void model(input logic [2:0] c, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] rh, output logic [31:0] rl);
        longint          sp;
        longint unsigned up;
        int              sx, sy;
        rh = hi_m;
        rl = lo_m;
        case (c)
            3'd1: begin
                sp = longint'($signed(x)) * longint'($signed(y));
                rh = sp[63:32];
                rl = sp[31:0];
            end
            3'd2: begin
                up = {32'd0, x} * {32'd0, y};
                rh = up[63:32];
                rl = up[31:0];
            end
            3'd3: if (y != 0) begin
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin
                    rl = x;
                    rh = 32'd0;
                end else begin
                    sx = x;
                    sy = y;
                    rl = sx / sy;
                    rh = sx % sy;
                end
            end
            3'd4: if (y != 0) begin
                rl = x / y;
                rh = x % y;
            end
            default: ;
        endcase
    endfunction

    task automatic op(input logic [2:0] ctr, input logic [31:0] x, input logic [31:0] y,
                      input int cancel_at, input int reset_at, input bit disturb,
                      input bit with_write);
        int          lat;
        logic [31:0] rh, rl;
        lat = lat_of(ctr);
        model(ctr, x, y, rh, rl);
        start = 1'b1;
        mdctr = ctr;
        a = x;
        b = y;
        if (with_write) begin
            hiwrite = 1'b1;
            lowrite = 1'b1;
            wdata = $urandom;
        end
        if (lat == 0) begin
            @(posedge clk);
            #1 start = 1'b0;
            hiwrite = 1'b0;
            lowrite = 1'b0;
            if (with_write) begin
                hi_m = wdata;
                lo_m = wdata;
            end
            check("invalid_busy", 64'(busy), 64'd0);
            check("invalid_hilo", {hi, lo}, {hi_m, lo_m});
            return;
        end
        if (cancel_at > 0) busy_exp.push_back(cancel_at);
        else if (reset_at == 0) begin
            busy_exp.push_back(lat);
            done_exp.push_back({rh, rl});
        end
        @(posedge clk);
        #1 start = 1'b0;
        hiwrite = 1'b0;
        lowrite = 1'b0;
        a = $urandom;
        b = $urandom;
        for (int k = 1; k <= lat; k++) begin
            if (k == cancel_at) cancel = 1'b1;
            if (disturb && k == 2) begin
                start = 1'b1;
                mdctr = 3'($urandom_range(1, 4));
                lowrite = 1'b1;
                wdata = $urandom;
            end
            if (k == reset_at) begin
                reset = 1'b0;
                #1;
                check("rst_busy", 64'(busy), 64'd0);
                check("rst_hilo", {hi, lo}, 64'd0);
                hi_m = 32'd0;
                lo_m = 32'd0;
            end
            @(posedge clk);
            #1 cancel = 1'b0;
            start = 1'b0;
            lowrite = 1'b0;
            reset = 1'b1;
        end
        if (cancel_at == 0 && reset_at == 0) begin
            hi_m = rh;
            lo_m = rl;
        end
        @(posedge clk);
        #1;
        check("hilo_after", {hi, lo}, {hi_m, lo_m});
        check("done_dropped", 64'(done), 64'd0);
    endtask

    task automatic wr(input bit hw, input bit lw, input logic [31:0] d, input bit cn);
        hiwrite = hw;
        lowrite = lw;
        wdata = d;
        cancel = cn;
        @(posedge clk);
        #1 hiwrite = 1'b0;
        lowrite = 1'b0;
        cancel = 1'b0;
        if (!cn) begin
            if (hw) hi_m = d;
            if (lw) lo_m = d;
        end
        check("mt_write", {hi, lo}, {hi_m, lo_m});
    endtask

    initial begin
        logic [2:0]  c;
        logic [31:0] x, y;
        int          r, lat, ca;
        reset = 1'b0;
        start = 1'b0;
        hiwrite = 1'b0;
        lowrite = 1'b0;
        cancel = 1'b0;
        mdctr = 3'd0;
        a = 32'd0;
        b = 32'd0;
        wdata = 32'd0;
        hi_m = 32'd0;
        lo_m = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        wr(1, 0, 32'h1234, 0);
        check("mthi_1234", 64'(hi), 64'h1234);

        op(3'd1, 32'hFFFFFFFF, 32'd2, 0, 0, 0, 0);
        check("mult_neg", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFFE});
        op(3'd2, 32'hFFFFFFFF, 32'd2, 0, 0, 0, 0);
        check("multu", {hi, lo}, {32'h00000001, 32'hFFFFFFFE});
        op(3'd3, 32'hFFFFFFF9, 32'd2, 0, 0, 0, 0);
        check("div_neg", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFFD});
        op(3'd4, 32'd7, 32'd2, 0, 0, 0, 0);
        check("divu", {hi, lo}, {32'd1, 32'd3});
        op(3'd3, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0, 0);
        check("div_ovf", {hi, lo}, {32'd0, 32'h80000000});

        wr(1, 0, 32'd5, 0);
        wr(0, 1, 32'd6, 0);
        op(3'd4, 32'd9, 32'd0, 0, 0, 0, 0);
        check("divu_zero", {hi, lo}, {32'd5, 32'd6});

        wr(1, 1, 32'd0, 0);
        op(3'd1, 32'd3, 32'd4, 3, 0, 0, 0);
        check("cancel_keep", {hi, lo}, 64'd0);
        op(3'd1, 32'd3, 32'd4, 0, 0, 1, 0);
        check("disturbed_mult", {hi, lo}, {32'd0, 32'd12});

        wr(1, 1, 32'hDEADBEEF, 1);
        op(3'd0, 32'd1, 32'd1, 0, 0, 0, 0);
        op(3'd6, 32'd1, 32'd1, 0, 0, 0, 1);
        op(3'd2, 32'd10, 32'd10, 0, 0, 0, 1);
        op(3'd3, 32'd100, 32'd7, DL, 0, 0, 0);
        op(3'd4, 32'd50, 32'd3, 0, 2, 0, 0);
        repeat (DL + 2) @(posedge clk);
        #1 check("no_late_commit", {hi, lo}, 64'd0);

        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            c = (r < 8) ? 3'(r % 4 + 1) : ((r == 8) ? 3'd0 : 3'($urandom_range(5, 7)));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: y = 32'd0;
                1: begin x = 32'h80000000; y = 32'hFFFFFFFF; end
                2: begin x = $urandom_range(0, 20) - 10; y = $urandom_range(0, 6) - 3; end
                default: ;
            endcase
            lat = lat_of(c);
            ca = (lat > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, lat) : 0;
            op(c, x, y, ca, 0, (ca == 0) && ($urandom_range(0, 4) == 0), $urandom_range(0, 5) == 0);
            if ($urandom_range(0, 2) == 0)
                wr(1'($urandom), 1'($urandom), $urandom, 1'($urandom_range(0, 3) == 0));
        end

        repeat (3) @(posedge clk);
        #1;
        check("busy_queue_empty", 64'(busy_exp.size()), 64'd0);
        check("done_queue_empty", 64'(done_exp.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
